// File: rtl/imem_loader.sv
// imem_loader: byte-stream writer for the instruction memory.
// Collects little-endian 32-bit words from a byte stream and writes them to
// consecutive word addresses starting at 0. Fetch is stalled for the whole
// load, and Done pulses once when the load completes.
module imem_loader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic [ADDR_WIDTH:0]   LenW,
    input  logic                  ByteValid,
    input  logic [7:0]            ByteIn,
    output logic                  ByteReady,
    output logic                  WE,
    output logic [ADDR_WIDTH-1:0] WA,
    output logic [DATA_WIDTH-1:0] WD,
    output logic                  StallF,
    output logic                  Busy,
    output logic                  Done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state;
    logic [1:0]            byte_cnt;
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic [ADDR_WIDTH-1:0] last_word;  // clamped length minus one
    logic [23:0]           asm_word;   // bytes 0..2; byte 3 goes straight to WD

    // Load sequencer; every output is a register updated alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            last_word <= '0;
            asm_word  <= '0;
            ByteReady <= 1'b0;
            WE        <= 1'b0;
            WA        <= '0;
            WD        <= '0;
            StallF    <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            WE   <= 1'b0;
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        byte_cnt <= '0;
                        word_cnt <= '0;
                        StallF   <= 1'b1;
                        Busy     <= 1'b1;
                        if (LenW != '0) begin
                            // Lengths at or above capacity clamp to a full memory
                            last_word <= LenW[ADDR_WIDTH] ? '1
                                       : LenW[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
                            ByteReady <= 1'b1;
                            state     <= S_RECV;
                        end else begin
                            Done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_RECV: begin
                    if (ByteValid && ByteReady) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: asm_word[7:0]   <= ByteIn;
                            2'd1: asm_word[15:8]  <= ByteIn;
                            2'd2: asm_word[23:16] <= ByteIn;
                            default: begin
                                WE        <= 1'b1;
                                WA        <= word_cnt;
                                WD        <= {ByteIn, asm_word};
                                ByteReady <= 1'b0;
                                state     <= S_WRITE;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    if (word_cnt == last_word) begin
                        Done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        word_cnt  <= word_cnt + ADDR_WIDTH'(1);
                        ByteReady <= 1'b1;
                        state     <= S_RECV;
                    end
                end
                S_DONE: begin
                    word_cnt <= '0;
                    StallF   <= 1'b0;
                    Busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    ByteReady <= 1'b0;
                    StallF    <= 1'b0;
                    Busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
